// File: rtl/flappy_pkg.sv
// ---------------------------------------------------------------------------
// flappy_pkg
//   Shared definitions for the game core: coordinate width, screen size,
//   the scheduler/game FSM state encoding and the LFSR step function.
// ---------------------------------------------------------------------------
package flappy_pkg;

    localparam int COORD_W  = 10;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    typedef logic [COORD_W-1:0] coord_t;

    // One-hot, matching the game FSM encoding style.
    typedef enum logic [2:0] {
        ST_IDLE = 3'b001,
        ST_RUN  = 3'b010,
        ST_HOLD = 3'b100
    } pipe_state_e;

    // 16-bit Fibonacci LFSR, taps 16,14,13,11 (bit 15 is tap 16).
    function automatic logic [15:0] lfsr16_next(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

endpackage

// File: rtl/lfsr16.sv
// ---------------------------------------------------------------------------
// lfsr16
//   Free-running 16-bit Fibonacci LFSR. Advances on every clock; reusable
//   for any randomised element of the game.
//
//   Parameters: SEED  reset value, must be non-zero
//   Ports:      Clk   system clock
//               Reset asynchronous, active-high
//               lfsr  current LFSR state
// ---------------------------------------------------------------------------
module lfsr16
    import flappy_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        Clk,
    input  logic        Reset,
    output logic [15:0] lfsr
);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            lfsr <= SEED;
        end else begin
            lfsr <= lfsr16_next(lfsr);
        end
    end

endmodule

// File: rtl/pipe_scheduler.sv
// ---------------------------------------------------------------------------
// pipe_scheduler
//   Manages the two pipe slots: spawns at the right edge, scrolls left once
//   per frame Tick, retires off-screen pipes and gives each new pipe a
//   pseudo-random gap height. An inactive slot always reads PARK_X so it can
//   never score or collide.
//
//   Optional build macro: PIPE_SPEEDUP_EN
//     defined   -> scroll speed starts at SPEED on leaving IDLE and steps up
//                  by 1 after every 8th spawn, saturating at 6.
//     undefined -> scroll speed is the constant SPEED.
//
//   Ports:
//     Clk, Reset          clock, asynchronous active-high reset
//     Tick                one-cycle frame strobe
//     Run                 level, high while the game is being played
//     Clear               one-cycle pulse, park both slots and go IDLE
//     XPipe1/YPipe1       slot 1 centre X / gap top Y
//     XPipe2/YPipe2       slot 2 centre X / gap top Y
//     Active1/Active2     slot holds a live pipe
//     SpawnPulse          high for the cycle after a slot is loaded
//
//   state | meaning
//   ------+-------------------------------------------------
//   IDLE  | slots parked, counter preset so first Tick spawns
//   RUN   | move / retire / count / spawn on each Tick
//   HOLD  | everything frozen, Tick ignored, resumes on Run
// ---------------------------------------------------------------------------
module pipe_scheduler
    import flappy_pkg::*;
#(
    parameter coord_t      SPAWN_X   = coord_t'(SCREEN_W),
    parameter coord_t      PARK_X    = 10'd1023,
    parameter logic [3:0]  SPEED     = 4'd2,
    parameter logic [7:0]  SPACING   = 8'd160,
    parameter coord_t      GAP_MIN   = 10'd60,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Tick,
    input  logic               Run,
    input  logic               Clear,
    output logic [COORD_W-1:0] XPipe1,
    output logic [COORD_W-1:0] YPipe1,
    output logic [COORD_W-1:0] XPipe2,
    output logic [COORD_W-1:0] YPipe2,
    output logic               Active1,
    output logic               Active2,
    output logic               SpawnPulse
);

    // Keeps the gap on-screen should GAP_MIN ever be overridden upward.
    localparam coord_t Y_MAX = coord_t'(SCREEN_H - 1);

    pipe_state_e state, state_nxt;
    logic [7:0]  cnt, cnt_nxt;
    coord_t      x1_nxt, y1_nxt, x2_nxt, y2_nxt;
    logic        a1_nxt, a2_nxt, spawn_nxt;
    logic        work, free1, free2;

    logic [15:0] lfsr_val;
    logic        unused_lfsr_hi;
    coord_t      gap_raw, gap_y;

    logic [3:0]  speed;
    coord_t      speed_ext;

    lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .Clk   (Clk),
        .Reset (Reset),
        .lfsr  (lfsr_val)
    );

    assign unused_lfsr_hi = ^lfsr_val[15:8];
    assign gap_raw        = GAP_MIN + {{(COORD_W-8){1'b0}}, lfsr_val[7:0]};
    assign gap_y          = (gap_raw > Y_MAX) ? Y_MAX : gap_raw;
    assign speed_ext      = {{(COORD_W-4){1'b0}}, speed};

`ifdef PIPE_SPEEDUP_EN
    localparam logic [3:0] SPEED_MAX = 4'd6;

    logic [3:0] speed_q, speed_nxt;
    logic [2:0] spawn_cnt_q, spawn_cnt_nxt;

    always_comb begin
        speed_nxt     = speed_q;
        spawn_cnt_nxt = spawn_cnt_q;
        if (Clear || (state == ST_IDLE && Run)) begin
            speed_nxt     = SPEED;
            spawn_cnt_nxt = 3'd0;
        end else if (spawn_nxt) begin
            spawn_cnt_nxt = spawn_cnt_q + 3'd1;
            // The 8th spawn of each group wraps the counter and steps speed.
            if (spawn_cnt_q == 3'd7 && speed_q < SPEED_MAX) begin
                speed_nxt = speed_q + 4'd1;
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            speed_q     <= SPEED;
            spawn_cnt_q <= 3'd0;
        end else begin
            speed_q     <= speed_nxt;
            spawn_cnt_q <= spawn_cnt_nxt;
        end
    end

    assign speed = speed_q;
`else
    assign speed = SPEED;
`endif

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        x1_nxt    = XPipe1;
        y1_nxt    = YPipe1;
        a1_nxt    = Active1;
        x2_nxt    = XPipe2;
        y2_nxt    = YPipe2;
        a2_nxt    = Active2;
        spawn_nxt = 1'b0;
        work      = 1'b0;
        free1     = ~Active1;
        free2     = ~Active2;

        case (state)
            ST_IDLE: begin
                if (Run) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                work = Tick;
                if (!Run) begin
                    state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (Run) begin
                    state_nxt = ST_RUN;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        if (work) begin
            // Move or retire; a retired slot is free for the spawn below.
            if (Active1) begin
                if (XPipe1 >= speed_ext) begin
                    x1_nxt = XPipe1 - speed_ext;
                end else begin
                    x1_nxt = PARK_X;
                    a1_nxt = 1'b0;
                    free1  = 1'b1;
                end
            end
            if (Active2) begin
                if (XPipe2 >= speed_ext) begin
                    x2_nxt = XPipe2 - speed_ext;
                end else begin
                    x2_nxt = PARK_X;
                    a2_nxt = 1'b0;
                    free2  = 1'b1;
                end
            end

            if (cnt < SPACING) begin
                cnt_nxt = cnt + 8'd1;
            end

            // Spawn decision uses the counter as it stood before this Tick;
            // with no free slot it stays saturated until one frees up.
            if (cnt == SPACING && (free1 || free2)) begin
                if (free1) begin
                    x1_nxt = SPAWN_X;
                    y1_nxt = gap_y;
                    a1_nxt = 1'b1;
                end else begin
                    x2_nxt = SPAWN_X;
                    y2_nxt = gap_y;
                    a2_nxt = 1'b1;
                end
                spawn_nxt = 1'b1;
                cnt_nxt   = 8'd1;
            end
        end

        if (Clear) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = SPACING;
            x1_nxt    = PARK_X;
            y1_nxt    = GAP_MIN;
            a1_nxt    = 1'b0;
            x2_nxt    = PARK_X;
            y2_nxt    = GAP_MIN;
            a2_nxt    = 1'b0;
            spawn_nxt = 1'b0;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state      <= ST_IDLE;
            cnt        <= SPACING;
            XPipe1     <= PARK_X;
            YPipe1     <= GAP_MIN;
            Active1    <= 1'b0;
            XPipe2     <= PARK_X;
            YPipe2     <= GAP_MIN;
            Active2    <= 1'b0;
            SpawnPulse <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            XPipe1     <= x1_nxt;
            YPipe1     <= y1_nxt;
            Active1    <= a1_nxt;
            XPipe2     <= x2_nxt;
            YPipe2     <= y2_nxt;
            Active2    <= a2_nxt;
            SpawnPulse <= spawn_nxt;
        end
    end

endmodule

// File: doc/pipe_scheduler.md
Name: pipe_scheduler

Overview:
- Sequences the two pipe slots for the game core: spawns pipes at the right edge, scrolls them left once per frame tick, retires them off-screen and assigns each new pipe a pseudo-random gap height.
- Drives the XPipe1/YPipe1/XPipe2/YPipe2 coordinates consumed by the game FSM (collision/scoring) and the renderer.
- Controlled by the game FSM through Run/Clear.

Parameters:
- SPAWN_X, 10'd640, X loaded into a slot on spawn.
- PARK_X, 10'd1023, X of an inactive slot; it must never score or collide.
- SPEED, 4'd2, pixels subtracted from each active X per Tick.
- SPACING, 8'd160, Ticks between successive spawns.
- GAP_MIN, 10'd60, minimum YPipe value.
- LFSR_SEED, 16'hACE1, LFSR reset value; must be non-zero.

Ports:
- Clk  in  1  system clock
- Reset  in  1  asynchronous, active-high
- Tick  in  1  one-cycle frame strobe (60 Hz)
- Run  in  1  level; high while the game FSM is in GAME
- Clear  in  1  one-cycle pulse; return to IDLE and park both slots
- XPipe1  out  10  slot 1 pipe centre X
- YPipe1  out  10  slot 1 gap top Y
- XPipe2  out  10  slot 2 pipe centre X
- YPipe2  out  10  slot 2 gap top Y
- Active1  out  1  slot 1 holds a live pipe
- Active2  out  1  slot 2 holds a live pipe
- SpawnPulse  out  1  one-cycle pulse on the cycle a slot is loaded

Behaviour:
- Reset, asynchronous: state=IDLE, XPipe1=XPipe2=PARK_X, YPipe1=YPipe2=GAP_MIN, Active1=Active2=0, SpawnPulse=0, spawn counter=SPACING, LFSR=LFSR_SEED.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. It advances on every clock in all states, so start time randomises the sequence.
- Gap height on spawn: Y = GAP_MIN + LFSR[7:0], zero-extended. Range is 60..315.
- States:
  - IDLE: slots parked. Run=1 -> RUN. The spawn counter is preset to SPACING, so the first Tick in RUN spawns.
  - RUN: all work happens only on cycles with Tick=1. Sub-steps evaluate in the same cycle, in this order:
    - (a) Move: each active slot with X >= SPEED gets X <= X - SPEED.
    - (b) Retire: an active slot with X < SPEED gets Active<=0 and X<=PARK_X. There is no wrap and no underflow.
    - (c) Count: if counter < SPACING, counter <= counter + 1.
    - (d) Spawn: if counter == SPACING and at least one slot is free after (b), load the lowest-numbered free slot (X=SPAWN_X, Y from LFSR, Active=1), pulse SpawnPulse and set counter <= 1.
  - Spawn when no slot is free: the counter saturates at SPACING and the spawn fires on the first Tick on which a slot is free.
  - A slot retired by (b) is spawnable by (d) in the same Tick.
  - Run=0 while in RUN -> HOLD.
  - HOLD: positions, flags and counter frozen; Tick ignored. Run=1 -> RUN, resuming where it stopped.
  - Clear, from any state: next cycle is IDLE with the reset values, except the LFSR keeps running. Clear has priority over Run and Tick in the same cycle.
- Latency: outputs are registered; updated values are visible the cycle after Tick.
- Outputs are never X. An inactive slot always reads PARK_X.

Optional Feature:
- PIPE_SPEEDUP_EN defined:
  - The effective speed register starts at SPEED on IDLE exit and is held in HOLD.
  - It increments by 1 after every 8th spawn, saturating at 4'd6.
  - The retire test uses the effective speed.
- PIPE_SPEEDUP_EN undefined: speed is the constant SPEED and no extra register exists.

Decomposition:
- Shared package flappy_pkg holds:
  - the state encoding (IDLE/RUN/HOLD, one-hot 3-bit, same style as the game FSM);
  - the screen constants SCREEN_W=640, SCREEN_H=480;
  - the 10-bit coordinate width.
- One sub-module, lfsr16 (Clk, Reset, seed parameter, 16-bit out). It is reusable for other randomised elements.

Test Plan:
- Reset mid-RUN with both slots active -> next cycle both X=1023, Active=0, state IDLE, LFSR=16'hACE1.
- Run=1 then the first Tick -> XPipe1=640, Active1=1, SpawnPulse high for 1 cycle, YPipe1 in 60..315. After 10 more Ticks, XPipe1=620.
- 160 Ticks after the first spawn -> slot 2 spawns at 640 while XPipe1=320.
- Slot 1 at X=1 with counter at SPACING on the same Tick -> slot 1 retired and respawned at 640 in that Tick. Slot 2 untouched.
- Run dropped for 50 Ticks then restored -> X and counter unchanged across HOLD, motion resumes on the next Tick.
- Clear and Tick in the same cycle -> IDLE, both slots parked, no movement applied.
